gf_mul_digit_ctrl: RTL and testbench

- Sequencer for an iterative MSB-first GF(2^m) multiplier: computes r = a·b mod f(x), with f(x) = x^DATA_WIDTH + g(x).
- Holds operands and the partial product t, and applies DIGIT chained bit-row reductions per clock until every bit of b has been consumed.
- Sits between the SoC operand interface (valid/ready) and the bit-row datapath; instantiates the bit rows internally.

---
 rtl/gf_mul_digit_ctrl.sv | 142 ++++++++++++++
 tb/tb_gf_mul_digit_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf_mul_digit_ctrl.sv
// Digit-serial MSB-first GF(2^m) multiplier sequencer: r = a*b mod (x^m + g(x)).
// Consumes DIGIT bits of b per clock through a chain of combinational bit rows.

module gf_mul_bit_row #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_t,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_g,
    input  logic         i_bk,
    output logic [W-1:0] o_t_c
);
    // Shift, fold the overflowing x^m term back through g, add a if the b bit is set.
    assign o_t_c = (i_t << 1) ^ ({W{i_t[W-1]}} & i_g) ^ ({W{i_bk}} & i_a);
endmodule

module gf_mul_digit_ctrl #(
    parameter int unsigned DATA_WIDTH = 163,
    parameter int unsigned DIGIT      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] g,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);
    localparam int unsigned N_ITER = (DATA_WIDTH + DIGIT - 1) / DIGIT;
    localparam int unsigned BW     = N_ITER * DIGIT;
    localparam int unsigned CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_a, w_a_nxt;
    logic [DATA_WIDTH-1:0] r_g, w_g_nxt;
    logic [BW-1:0]         r_b, w_b_nxt;
    logic [DATA_WIDTH-1:0] r_t, w_t_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_result, w_result_nxt;
    logic                  r_res_valid, w_res_valid_nxt;
    logic [DATA_WIDTH-1:0] w_last;

    // Chain of DIGIT bit rows; row k consumes the k-th most significant remaining b bit.
    for (genvar k = 0; k < DIGIT; k++) begin : g_row
        logic [DATA_WIDTH-1:0] w_in;
        logic [DATA_WIDTH-1:0] w_out;
        if (k == 0) begin : g_first
            assign w_in = r_t;
        end else begin : g_next
            assign w_in = g_row[k-1].w_out;
        end
        gf_mul_bit_row #(.W(DATA_WIDTH)) u_row (
            .i_t   (w_in),
            .i_a   (r_a),
            .i_g   (r_g),
            .i_bk  (r_b[BW-1-k]),
            .o_t_c (w_out)
        );
    end
    assign w_last = g_row[DIGIT-1].w_out;

    // Next-state and datapath register updates.
    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_g_nxt         = r_g;
        w_b_nxt         = r_b;
        w_t_nxt         = r_t;
        w_cnt_nxt       = r_cnt;
        w_result_nxt    = r_result;
        w_res_valid_nxt = r_res_valid;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = RUN;
                    w_a_nxt     = a;
                    w_g_nxt     = g;
                    w_b_nxt     = BW'(b);
                    w_t_nxt     = '0;
                    w_cnt_nxt   = '0;
                end
            end
            RUN: begin
                w_t_nxt   = w_last;
                w_b_nxt   = r_b << DIGIT;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(N_ITER - 1)) begin
                    w_state_nxt     = HOLD;
                    w_result_nxt    = w_last;
                    w_res_valid_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    w_state_nxt     = IDLE;
                    w_res_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_res_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_g         <= '0;
            r_b         <= '0;
            r_t         <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_g         <= w_g_nxt;
            r_b         <= w_b_nxt;
            r_t         <= w_t_nxt;
            r_cnt       <= w_cnt_nxt;
            r_result    <= w_result_nxt;
            r_res_valid <= w_res_valid_nxt;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == RUN) || (r_state == HOLD);
    assign res_valid = r_res_valid;
    assign result    = r_result;
endmodule

// File: tb/tb_gf_mul_digit_ctrl.sv
// Directed bench for gf_mul_digit_ctrl: three configurations (8/3, 8/1, 163/16)
// driven from shared operand buses, checked against constants and a bit-serial model.

module tb_gf_mul_digit_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic [162:0] a, b, g;
    logic         iv [3];
    logic         rr [3];
    logic         ir [3];
    logic         rv [3];
    logic         by [3];
    logic [7:0]   r0, r1;
    logic [162:0] r2;
    logic [162:0] res [3];
    int           n_iter [3];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign res[0] = 163'(r0);
    assign res[1] = 163'(r1);
    assign res[2] = r2;

    gf_mul_digit_ctrl #(.DATA_WIDTH(8), .DIGIT(3)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a[7:0]), .b(b[7:0]), .g(g[7:0]), .res_valid(rv[0]),
        .res_ready(rr[0]), .result(r0), .busy(by[0])
    );
    gf_mul_digit_ctrl #(.DATA_WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a[7:0]), .b(b[7:0]), .g(g[7:0]), .res_valid(rv[1]),
        .res_ready(rr[1]), .result(r1), .busy(by[1])
    );
    gf_mul_digit_ctrl #(.DATA_WIDTH(163), .DIGIT(16)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a), .b(b), .g(g), .res_valid(rv[2]),
        .res_ready(rr[2]), .result(r2), .busy(by[2])
    );

    task automatic check_val(input string tag, input logic [162:0] got, input logic [162:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Plain shift-and-add reference, one b bit at a time.
    function automatic logic [162:0] gf_ref(input logic [162:0] x, input logic [162:0] y,
                                            input logic [162:0] p, input int w);
        logic [162:0] t, mask;
        logic         msb;
        mask = '1;
        mask = mask >> (163 - w);
        t    = '0;
        for (int i = w - 1; i >= 0; i--) begin
            msb = t[w-1];
            t   = (t << 1) & mask;
            if (msb)  t = t ^ (p & mask);
            if (y[i]) t = t ^ (x & mask);
        end
        return t;
    endfunction

    function automatic logic [162:0] rnd163();
        return 163'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    // One multiply; in_valid stays high with junk operands until the result shows.
    task automatic run_mul(input int u, input logic [162:0] xa, input logic [162:0] xb,
                           input logic [162:0] xg, input logic [162:0] exp,
                           input int hold, input string tag);
        int lat;
        bit done;
        @(negedge clk);
        check_val({tag, "_ready_idle"}, 163'(ir[u]), 163'(1));
        a = xa; b = xb; g = xg;
        iv[u] = 1'b1;
        rr[u] = (hold == 0);
        @(posedge clk);
        #1 a = ~xa; b = ~xb; g = ~xg;
        @(negedge clk);
        check_val({tag, "_busy_run"}, 163'(by[u]), 163'(1));
        check_val({tag, "_ready_run"}, 163'(ir[u]), 163'(0));
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 64) begin
            if (rv[u]) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
        end
        check_val({tag, "_valid_seen"}, 163'(done), 163'(1));
        check_val({tag, "_latency"}, 163'(lat), 163'(n_iter[u]));
        check_val({tag, "_result"}, res[u], exp);
        check_val({tag, "_ready_hold"}, 163'(ir[u]), 163'(0));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val({tag, "_hold_valid"}, 163'(rv[u]), 163'(1));
            check_val({tag, "_hold_result"}, res[u], exp);
        end
        rr[u] = 1'b1;
        iv[u] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val({tag, "_valid_drop"}, 163'(rv[u]), 163'(0));
        check_val({tag, "_ready_back"}, 163'(ir[u]), 163'(1));
        check_val({tag, "_result_kept"}, res[u], exp);
    endtask

    // in_valid held high throughout; accepts spaced by RUN + HOLD + IDLE cycles.
    task automatic run_b2b();
        logic [162:0] opa [3];
        logic [162:0] opb [3];
        logic [162:0] ex  [3];
        int           t_acc, t_prev, k;
        opa = '{163'h57, 163'h57, 163'h57};
        opb = '{163'h83, 163'h13, 163'h01};
        ex  = '{163'hC1, 163'hFE, 163'h57};
        t_prev = 0;
        @(negedge clk);
        g = 163'h1B;
        rr[0] = 1'b1;
        iv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            while (!ir[0] && k < 20) begin
                @(negedge clk);
                k++;
            end
            check_val("b2b_ready", 163'(ir[0]), 163'(1));
            a = opa[i]; b = opb[i];
            @(posedge clk);
            #1 t_acc = cyc;
            a = ~opa[i]; b = ~opb[i];
            if (i > 0) check_val("b2b_interval", 163'(t_acc - t_prev), 163'(n_iter[0] + 2));
            t_prev = t_acc;
            k = 0;
            @(negedge clk);
            while (!rv[0] && k < 20) begin
                @(negedge clk);
                k++;
            end
            check_val("b2b_result", res[0], ex[i]);
        end
        iv[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("b2b_idle", 163'(ir[0]), 163'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [162:0] ra, rb, rg;
        n_iter = '{3, 8, 11};
        rst = 1'b1;
        a = '0; b = '0; g = '0;
        for (int u = 0; u < 3; u++) begin
            iv[u] = 1'b0;
            rr[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            check_val("rst_ready", 163'(ir[u]), 163'(1));
            check_val("rst_valid", 163'(rv[u]), 163'(0));
            check_val("rst_busy", 163'(by[u]), 163'(0));
            check_val("rst_result", res[u], 163'(0));
        end

        run_mul(0, 163'h57, 163'h83, 163'h1B, 163'hC1, 0, "d3_57x83");
        run_mul(0, 163'h57, 163'h13, 163'h1B, 163'hFE, 5, "d3_57x13_hold");

        run_mul(1, 163'h57, 163'h83, 163'h1B, 163'hC1, 0, "d1_57x83");
        run_mul(1, 163'h00, 163'h83, 163'h1B, 163'h00, 0, "d1_zero_a");
        run_mul(1, 163'hA5, 163'h01, 163'h1B, 163'hA5, 0, "d1_b_one");

        run_mul(2, 163'h1, 163'h1 << 162, 163'hC9, 163'h1 << 162, 0, "d16_one");
        run_mul(2, 163'h2, 163'h1 << 162, 163'hC9, 163'hC9, 0, "d16_x163");
        for (int i = 0; i < 3; i++) begin
            ra = rnd163();
            rb = rnd163();
            run_mul(2, ra, rb, 163'hC9, gf_ref(ra, rb, 163'hC9, 163), 0, "d16_rand");
        end
        ra = rnd163(); rb = rnd163(); rg = rnd163();
        run_mul(2, ra, rb, rg, gf_ref(ra, rb, rg, 163), 0, "d16_rand_g");
        ra = 163'(8'h3C); rb = 163'(8'hE7);
        run_mul(0, ra, rb, 163'h1B, gf_ref(ra, rb, 163'h1B, 8), 2, "d3_model");

        // Reset during the second RUN cycle discards the operation.
        @(negedge clk);
        a = 163'h57; b = 163'h83; g = 163'h1B;
        iv[0] = 1'b1;
        rr[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_ready", 163'(ir[0]), 163'(1));
        check_val("mid_rst_valid", 163'(rv[0]), 163'(0));
        check_val("mid_rst_result", res[0], 163'(0));
        check_val("mid_rst_busy", 163'(by[0]), 163'(0));
        repeat (5) @(negedge clk);
        check_val("mid_rst_no_valid", 163'(rv[0]), 163'(0));
        run_mul(0, 163'h57, 163'h83, 163'h1B, 163'hC1, 0, "after_rst");

        run_b2b();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
